serial_subtractor: RTL

Bit-serial, LSB-first binary subtractor that computes `a - b` one bit per clock using a single full-subtractor cell and a registered borrow. It is the subtracting counterpart of the team's adder cells: the half/full adder produces sum and carry, and this block produces difference and borrow. A start/done handshake makes it usable as a small arithmetic co-unit that a controller launches and then polls. The result and the final borrow are held until the next operation completes.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first unsigned subtractor (a - b).
// One full-subtractor cell with a registered borrow consumes one operand bit
// per clock. A start/done handshake launches the operation. The result and
// the final borrow are held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  // Holds the WIDTH-1 difference bits produced before the final one.
  logic [WIDTH-2:0]   wd_q, wd_d;
  logic               bin_q, bin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bit_d;
  logic               bit_bout;
  logic [WIDTH-1:0]   shifted;

  // Full-subtractor cell on the current LSBs and the working register with
  // the new difference bit entering at the MSB.
  always_comb begin
    bit_d    = sa_q[0] ^ sb_q[0] ^ bin_q;
    bit_bout = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bin_q);
    shifted  = {bit_d, wd_q};
  end

  // Next-state and datapath logic; every register holds unless its state acts.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    wd_d     = wd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        wd_d  = shifted[WIDTH-1:1];
        bin_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = shifted;
          borrow_d = bit_bout;
          state_d  = DONE;
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      wd_q     <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      wd_q     <= wd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
